// File: rtl/stdp_synapse_array_if.sv
// Signal bundle for the STDP synapse array: learning controls, spike inputs, weight read port
// and scan status. The master side drives the neuron/learning inputs; the slave side is the array.
interface stdp_synapse_array_if #(
  parameter int unsigned N_PRE   = 16,
  parameter int unsigned WIN     = 8,
  parameter int unsigned W_WIDTH = 4
);
  localparam int unsigned AW = $clog2(N_PRE);
  localparam int unsigned DW = $clog2(WIN) + 1;

  logic                 write;
  logic [N_PRE-1:0]     pre_spike;
  logic                 post_spike;
  logic [AW-1:0]        rd_addr;
  logic [W_WIDTH-1:0]   rd_weight;
  logic                 busy;
  logic                 update_done;
  logic signed [DW-1:0] dt_last;

  modport master (
    output write, pre_spike, post_spike, rd_addr,
    input  rd_weight, busy, update_done, dt_last
  );

  modport slave (
    input  write, pre_spike, post_spike, rd_addr,
    output rd_weight, busy, update_done, dt_last
  );
endinterface

// File: rtl/stdp_synapse_array.sv
// STDP learning engine for one postsynaptic neuron: per-channel spike history, and on each
// postsynaptic spike a one-synapse-per-cycle scan applying saturating LTP/LTD to the weights.
module stdp_synapse_array #(
  parameter int unsigned N_PRE    = 16,
  parameter int unsigned WIN      = 8,
  parameter int unsigned W_WIDTH  = 4,
  parameter int unsigned W_INIT   = 8,
  parameter int unsigned LTP_STEP = 1,
  parameter int unsigned LTD_STEP = 1
) (
  input logic                clock,
  input logic                reset,
  stdp_synapse_array_if.slave bus
);
  localparam int unsigned AW = $clog2(N_PRE);
  localparam int unsigned AB = $clog2(WIN);
  localparam int unsigned DW = AB + 1;
  localparam int unsigned CW = W_WIDTH + 2;
  localparam logic [W_WIDTH-1:0] WMax = '1;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e               state_q;
  logic                 pending_q;
  logic [AW-1:0]        idx_q;
  logic                 busy_q;
  logic                 update_done_q;
  logic signed [DW-1:0] dt_last_q;

  // History keeps only ages 1..WIN-1; age 0 is the live pre_spike input.
  logic [WIN-2:0]       hist_q   [N_PRE];
  logic [WIN-1:0]       cur      [N_PRE];
  logic [WIN-1:0]       snap_q   [N_PRE];
  logic [W_WIDTH-1:0]   weight_q [N_PRE];

  logic                 trigger;
  logic [WIN-1:0]       snap_sel;
  logic                 hit;
  logic [AB-1:0]        age;
  logic signed [CW-1:0] w_ext;
  logic signed [CW-1:0] sum;
  logic [W_WIDTH-1:0]   w_new;
  logic signed [DW-1:0] dt_new;
  logic [W_WIDTH-1:0]   rd_weight_c;

  assign trigger = bus.post_spike & bus.write;

  always_comb begin
    for (int i = 0; i < N_PRE; i++) begin
      cur[i] = {hist_q[i], bus.pre_spike[i]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_PRE; i++) hist_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_PRE; i++) hist_q[i] <= cur[i][WIN-2:0];
    end
  end

  // Youngest pre spike in the snapshot of the synapse currently being scanned.
  always_comb begin
    snap_sel = snap_q[idx_q];
    hit      = 1'b0;
    age      = '0;
    for (int j = WIN - 1; j >= 0; j--) begin
      if (snap_sel[j]) begin
        hit = 1'b1;
        age = AB'(j);
      end
    end
  end

  always_comb begin
    w_ext = $signed({2'b00, weight_q[idx_q]});
    if (hit) begin
      if ({1'b0, age} < DW'(WIN / 2)) sum = w_ext + $signed(CW'(2 * LTP_STEP));
      else                            sum = w_ext + $signed(CW'(LTP_STEP));
    end else begin
      sum = w_ext - $signed(CW'(LTD_STEP));
    end
    if (sum[CW-1])                         w_new = '0;
    else if (sum > $signed({2'b00, WMax})) w_new = WMax;
    else                                   w_new = sum[W_WIDTH-1:0];
    dt_new = hit ? $signed({1'b0, age}) : '1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      pending_q     <= 1'b0;
      idx_q         <= '0;
      busy_q        <= 1'b0;
      update_done_q <= 1'b0;
      dt_last_q     <= '0;
      for (int i = 0; i < N_PRE; i++) begin
        snap_q[i]   <= '0;
        weight_q[i] <= W_WIDTH'(W_INIT);
      end
    end else begin
      update_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (trigger) begin
            for (int i = 0; i < N_PRE; i++) snap_q[i] <= cur[i];
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StScan;
          end
        end
        StScan: begin
          weight_q[idx_q] <= w_new;
          dt_last_q       <= dt_new;
          if (trigger) pending_q <= 1'b1;
          if (idx_q == AW'(N_PRE - 1)) begin
            update_done_q <= 1'b1;
            state_q       <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          // A spike arriving in DONE is serviced by the same restart as an older pending one.
          if (pending_q || trigger) begin
            for (int i = 0; i < N_PRE; i++) snap_q[i] <= cur[i];
            pending_q <= 1'b0;
            idx_q     <= '0;
            state_q   <= StScan;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    rd_weight_c = '0;
    for (int i = 0; i < N_PRE; i++) begin
      if (bus.rd_addr == AW'(i)) rd_weight_c = weight_q[i];
    end
  end

  assign bus.rd_weight   = rd_weight_c;
  assign bus.busy        = busy_q;
  assign bus.update_done = update_done_q;
  assign bus.dt_last     = dt_last_q;
endmodule

// File: tb/tb_stdp_synapse_array.sv
// Bench for stdp_synapse_array: directed scenarios plus randomized traffic, all compared against
// a cycle-level behavioural model of the learning rules.
module tb_stdp_synapse_array;
  localparam int N     = 16;
  localparam int WIN   = 8;
  localparam int WW    = 4;
  localparam int WINIT = 8;
  localparam int LTP   = 1;
  localparam int LTD   = 1;
  localparam int WMAX  = (1 << WW) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;

  stdp_synapse_array_if #(.N_PRE(N), .WIN(WIN), .W_WIDTH(WW)) bus ();

  stdp_synapse_array #(
    .N_PRE(N), .WIN(WIN), .W_WIDTH(WW), .W_INIT(WINIT), .LTP_STEP(LTP), .LTD_STEP(LTD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #50 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Model: weights, past pre vectors (index 0 = one cycle ago), scan job progress.
  int             w_m [N];
  logic [N-1:0]   past_m [WIN-1];
  int             ages_m [N][$];
  int             job_pos;     // -1 idle, 0..N-1 synapse being scanned, N = done cycle
  bit             pend_m;
  int             dt_m;
  logic           obs_busy;
  logic           obs_done;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      w_m[i] = WINIT;
      ages_m[i].delete();
    end
    for (int k = 0; k < WIN - 1; k++) past_m[k] = '0;
    job_pos = -1;
    pend_m  = 0;
    dt_m    = 0;
  endtask

  // Record, per channel, every age within the window at which a pre spike occurred.
  task automatic take_snapshot(input logic [N-1:0] pre);
    for (int i = 0; i < N; i++) begin
      ages_m[i].delete();
      if (pre[i]) ages_m[i].push_back(0);
      for (int a = 1; a < WIN; a++) if (past_m[a-1][i]) ages_m[i].push_back(a);
    end
  endtask

  task automatic model_edge(input logic [N-1:0] pre, input logic post, input logic wr);
    bit trig;
    trig = post && wr;
    if (job_pos >= 0 && job_pos < N) begin
      int nw;
      if (ages_m[job_pos].size() == 0) begin
        nw   = w_m[job_pos] - LTD;
        dt_m = -1;
      end else begin
        int youngest;
        youngest = ages_m[job_pos].min()[0];
        nw   = w_m[job_pos] + ((youngest < WIN / 2) ? 2 * LTP : LTP);
        dt_m = youngest;
      end
      w_m[job_pos] = (nw < 0) ? 0 : (nw > WMAX) ? WMAX : nw;
      if (trig) pend_m = 1;
      job_pos++;
    end else if (job_pos == N) begin
      if (pend_m || trig) begin
        take_snapshot(pre);
        pend_m  = 0;
        job_pos = 0;
      end else begin
        job_pos = -1;
      end
    end else if (trig) begin
      take_snapshot(pre);
      job_pos = 0;
    end
    for (int k = WIN - 2; k > 0; k--) past_m[k] = past_m[k-1];
    past_m[0] = pre;
  endtask

  task automatic step(input logic [N-1:0] pre, input logic post, input logic wr);
    int addr;
    bus.pre_spike  = pre;
    bus.post_spike = post;
    bus.write      = wr;
    @(posedge clock);
    model_edge(pre, post, wr);
    #1;
    addr = $urandom_range(N - 1);
    bus.rd_addr = addr[3:0];
    #1;
    check("busy", int'(bus.busy), int'(job_pos >= 0));
    check("update_done", int'(bus.update_done), int'(job_pos == N));
    check("dt_last", int'($signed(bus.dt_last)), dt_m);
    check("rd_weight", int'(bus.rd_weight), w_m[addr]);
    obs_busy = bus.busy;
    obs_done = bus.update_done;
  endtask

  task automatic idle_steps(input int n);
    for (int k = 0; k < n; k++) step('0, 1'b0, 1'b1);
  endtask

  task automatic read_w(input int addr, output int val);
    bus.rd_addr = addr[3:0];
    #1;
    val = int'(bus.rd_weight);
  endtask

  task automatic check_all_weights(input string tag);
    int v;
    for (int a = 0; a < N; a++) begin
      read_w(a, v);
      check(tag, v, w_m[a]);
    end
  endtask

  task automatic expect_w(input string tag, input int addr, input int val);
    int v;
    read_w(addr, v);
    check(tag, v, val);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before any clock edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.update_done), 0);
    check("reset_dt", int'($signed(bus.dt_last)), 0);
    for (int a = 0; a < N; a++) expect_w("reset_weight", a, WINIT);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (obs_busy && n < 100) begin
      step('0, 1'b0, 1'b1);
      n++;
    end
    if (n >= 100) check("idle_timeout", 1, 0);
  endtask

  initial begin
    int cnt, done_cnt, done_at;
    logic [N-1:0] pre;
    bus.write = 1'b0; bus.pre_spike = '0; bus.post_spike = 1'b0; bus.rd_addr = '0;
    obs_busy = 1'b0; obs_done = 1'b0;
    model_reset();
    @(posedge clock);
    #1 reset = 1'b0;
    #20;
    do_reset();

    // Near LTP on ch3; silent channels depress; update_done on the 17th cycle.
    done_at = 0;
    step(16'h0008, 1'b1, 1'b1);
    for (int k = 2; k <= 40 && done_at == 0; k++) begin
      step('0, 1'b0, 1'b1);
      if (obs_done) done_at = k;
    end
    check("near_done_cycle", done_at, N + 1);
    wait_idle();
    expect_w("near_ltp_w3", 3, 10);
    expect_w("near_ltd_w0", 0, 7);
    check_all_weights("near_all");

    // Far LTP on ch5: pre six cycles before post.
    do_reset();
    step(16'h0020, 1'b0, 1'b1);
    idle_steps(5);
    step('0, 1'b1, 1'b1);
    idle_steps(N);
    check("far_dt_last", int'($signed(bus.dt_last)), -1);
    wait_idle();
    expect_w("far_ltp_w5", 5, 9);

    // Saturation at both ends.
    do_reset();
    for (int p = 0; p < 9; p++) begin
      step(16'h0001, 1'b1, 1'b1);
      wait_idle();
      if (p == 0) expect_w("sat_w0_1", 0, 10);
      if (p == 3) expect_w("sat_w0_4", 0, 15);
    end
    expect_w("sat_w0_max", 0, WMAX);
    expect_w("sat_w1_floor", 1, 0);

    // Pending: second spike at scan idx 4, third during the same scan is dropped.
    do_reset();
    cnt = 0; done_cnt = 0;
    step(16'h0004, 1'b1, 1'b1);
    if (obs_busy) cnt++;
    for (int k = 1; k < 50; k++) begin
      step('0, (k == 5) || (k == 9), 1'b1);
      if (obs_busy && cnt == k) cnt++;
      if (obs_done) done_cnt++;
    end
    check("pending_busy_run", cnt, 2 * (N + 1));
    check("pending_done_count", done_cnt, 2);

    // write=0 freezes learning.
    do_reset();
    for (int k = 0; k < 50; k++) step(16'($urandom), 1'b1, 1'b0);
    check("frozen_busy", int'(obs_busy), 0);
    check_all_weights("frozen_w");

    // Reset during scan idx 7 discards partial updates.
    step('0, 1'b1, 1'b1);
    idle_steps(7);
    do_reset();
    check_all_weights("midscan_reset_w");

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(499) == 0) begin
        do_reset();
      end else begin
        pre = 16'($urandom & $urandom & $urandom);
        step(pre, $urandom_range(9) == 0, $urandom_range(7) != 0);
      end
    end
    wait_idle();
    check_all_weights("random_final_w");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
